// File: rtl/argmax_scheduler.sv
// Sequencing controller for the output-layer argmax unit: packs a serial neuron
// stream into one vector, launches argmax, watches for a timeout, returns the class.
module argmax_scheduler #(
    parameter int numInput      = 10,
    parameter int inputWidth    = 16,
    parameter int classWidth    = 4,
    parameter int timeoutCycles = 64,
    parameter int countWidth    = 16
) (
    input  logic                           i_clk,
    input  logic                           reset_n,
    input  logic [inputWidth-1:0]          s_data,
    input  logic                           s_valid,
    output logic                           s_ready,
    output logic [numInput*inputWidth-1:0] mf_data,
    output logic                           mf_valid,
    input  logic [31:0]                    mf_result,
    input  logic                           mf_result_valid,
    output logic [classWidth-1:0]          o_class,
    output logic                           o_class_valid,
    input  logic                           i_class_ready,
    input  logic                           i_err_clr,
    output logic                           o_timeout_err,
    output logic                           o_busy,
    output logic [countWidth-1:0]          o_frame_count
);
    localparam int IdxW  = $clog2(numInput);
    localparam int WaitW = $clog2(timeoutCycles);
    localparam logic [IdxW-1:0]  LastIdx  = IdxW'(numInput - 1);
    localparam logic [WaitW-1:0] LastWait = WaitW'(timeoutCycles - 1);

    typedef enum logic [1:0] {
        ST_COLLECT,
        ST_LAUNCH,
        ST_WAIT,
        ST_HOLD
    } state_t;

    state_t                                  state;
    logic [IdxW-1:0]                         idx;
    logic [WaitW-1:0]                        wait_cnt;
    logic [numInput-1:0][inputWidth-1:0]     slots;

    // Only the low classWidth bits of the argmax index are meaningful here.
    logic unused_result;
    assign unused_result = ^mf_result[31:classWidth];

    assign mf_data = slots;
    assign s_ready = (state == ST_COLLECT);
    assign o_busy  = (state == ST_LAUNCH) || (state == ST_WAIT);

    always_ff @(posedge i_clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_COLLECT;
            idx           <= '0;
            wait_cnt      <= '0;
            slots         <= '0;
            mf_valid      <= 1'b0;
            o_class       <= '0;
            o_class_valid <= 1'b0;
            o_timeout_err <= 1'b0;
            o_frame_count <= '0;
        end else begin
            mf_valid <= 1'b0;
            // A timeout raised below in the same cycle overrides this clear.
            if (i_err_clr) o_timeout_err <= 1'b0;

            case (state)
                ST_COLLECT: begin
                    if (s_valid) begin
                        slots[idx] <= s_data;
                        if (idx == LastIdx) begin
                            idx      <= '0;
                            mf_valid <= 1'b1;
                            state    <= ST_LAUNCH;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end

                ST_LAUNCH: begin
                    wait_cnt <= '0;
                    state    <= ST_WAIT;
                end

                ST_WAIT: begin
                    // The first wait cycle can still see the previous frame's valid level.
                    if (mf_result_valid && (wait_cnt != '0)) begin
                        o_class       <= mf_result[classWidth-1:0];
                        o_class_valid <= 1'b1;
                        state         <= ST_HOLD;
                    end else if (wait_cnt == LastWait) begin
                        o_timeout_err <= 1'b1;
                        state         <= ST_COLLECT;
                    end
                    wait_cnt <= wait_cnt + 1'b1;
                end

                ST_HOLD: begin
                    if (i_class_ready) begin
                        o_class_valid <= 1'b0;
                        o_frame_count <= o_frame_count + 1'b1;
                        state         <= ST_COLLECT;
                    end
                end

                default: state <= ST_COLLECT;
            endcase
        end
    end
endmodule
